// File: rtl/hit_sound_controller_pkg.sv
// hit_sound_controller_pkg: hit classes, FSM states and counter sizing shared by the hit-sound logic
package hit_sound_controller_pkg;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_FLY    = 2'd1,
        CLS_MOSQ   = 2'd2,
        CLS_SPIDER = 2'd3
    } hit_cls_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TONE1 = 2'd1,
        ST_GAP   = 2'd2,
        ST_TONE2 = 2'd3
    } hit_state_e;

    // Width needed to count up to the largest of the segment lengths and half-periods.
    function automatic int cnt_width(input int a, input int b, input int c,
                                     input int d, input int e, input int f);
        int m;
        m = a;
        m = b > m ? b : m;
        m = c > m ? c : m;
        m = d > m ? d : m;
        m = e > m ? e : m;
        m = f > m ? f : m;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/hit_sound_controller_if.sv
// hit_sound_controller_if: enemy hit vectors, sound enables and buzzer/score outputs
//  master: drives sound_en, bullet_hit_*, fire_buzz; observes buzz, hit_active, hit_count
//  slave : the hit sound controller
interface hit_sound_controller_if #(
    parameter int BULLET_COUNT = 8
);
    logic                    sound_en;
    logic [BULLET_COUNT-1:0] bullet_hit_fly;
    logic [BULLET_COUNT-1:0] bullet_hit_mosquito;
    logic [BULLET_COUNT-1:0] bullet_hit_spider;
    logic                    fire_buzz;
    logic                    buzz;
    logic                    hit_active;
    logic [7:0]              hit_count;

    modport master (
        output sound_en, bullet_hit_fly, bullet_hit_mosquito, bullet_hit_spider, fire_buzz,
        input  buzz, hit_active, hit_count
    );

    modport slave (
        input  sound_en, bullet_hit_fly, bullet_hit_mosquito, bullet_hit_spider, fire_buzz,
        output buzz, hit_active, hit_count
    );
endinterface

// File: rtl/hit_sound_controller_tone_gen.sv
// tone_gen: square wave toggling every half_period cycles while run is high
//  clk25/reset : clock, asynchronous active-high reset
//  restart     : clears phase counter and output (output starts low)
//  run         : advance the phase counter
//  half_period : cycles per half wave
//  square      : tone output
module tone_gen #(
    parameter int W = 16
) (
    input  logic         clk25,
    input  logic         reset,
    input  logic         restart,
    input  logic         run,
    input  logic [W-1:0] half_period,
    output logic         square
);
    logic [W-1:0] cnt_q, cnt_d;
    logic         sq_q, sq_d, wrap;

    always_comb begin
        wrap  = cnt_q == half_period - W'(1);
        cnt_d = restart ? '0 : run ? (wrap ? '0 : cnt_q + W'(1)) : cnt_q;
        sq_d  = restart ? 1'b0 : (run & wrap) ? ~sq_q : sq_q;
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            sq_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sq_q  <= sq_d;
        end
    end

    assign square = sq_q;
endmodule

// File: rtl/hit_sound_controller.sv
// hit_sound_controller: class-specific hit tones muxed with fire buzz, plus saturating hit counter
//  clk25/reset : 25 MHz clock, asynchronous active-high reset
//  bus (slave) : sound_en, bullet_hit_{fly,mosquito,spider}, fire_buzz in;
//                buzz (registered), hit_active, hit_count out
module hit_sound_controller
    import hit_sound_controller_pkg::*;
#(
    parameter int FLY_HALF      = 12500,
    parameter int MOSQ_HALF     = 18939,
    parameter int SPIDER_HALF_A = 28409,
    parameter int SPIDER_HALF_B = 14204,
    parameter int TONE_LEN      = 2500000,
    parameter int GAP_LEN       = 250000
) (
    input logic                   clk25,
    input logic                   reset,
    hit_sound_controller_if.slave bus
);
    localparam int CW = cnt_width(TONE_LEN, GAP_LEN, FLY_HALF, MOSQ_HALF, SPIDER_HALF_A, SPIDER_HALF_B);
    localparam logic [CW-1:0] TONE_END = CW'(TONE_LEN - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_LEN - 1);

    function automatic logic [CW-1:0] half_of(input hit_cls_e c);
        return c == CLS_SPIDER ? CW'(SPIDER_HALF_A) : c == CLS_MOSQ ? CW'(MOSQ_HALF) : CW'(FLY_HALF);
    endfunction

    hit_state_e    state_q, state_d;
    hit_cls_e      cur_q, cur_d, pend_q, pend_d, evt_cls, pend_eff, next_cls;
    logic [CW-1:0] seg_cnt_q, seg_cnt_d, half_q, half_d;
    logic [2:0]    prev_q, prev_d, evt;
    logic [7:0]    hit_count_q, hit_count_d;
    logic [8:0]    cnt_sum;
    logic          buzz_q, buzz_d, restart, run, busy, square, tone_out, seg_end, to_idle;

    // Rising edge of "any bullet hit" per class; bit 0 fly, 1 mosquito, 2 spider.
    always_comb begin
        prev_d      = {|bus.bullet_hit_spider, |bus.bullet_hit_mosquito, |bus.bullet_hit_fly};
        evt         = prev_d & ~prev_q;
        evt_cls     = evt[2] ? CLS_SPIDER : evt[1] ? CLS_MOSQ : evt[0] ? CLS_FLY : CLS_NONE;
        cnt_sum     = 9'(hit_count_q) + 9'(evt[0]) + 9'(evt[1]) + 9'(evt[2]);
        hit_count_d = cnt_sum[8] ? 8'hff : cnt_sum[7:0];
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        pend_d    = pend_q;
        half_d    = half_q;
        seg_cnt_d = seg_cnt_q + CW'(1);
        restart   = 1'b0;
        next_cls  = CLS_NONE;
        seg_end   = seg_cnt_q == (state_q == ST_GAP ? GAP_END : TONE_END);
        to_idle   = seg_end & (state_q == ST_TONE2 | (state_q == ST_TONE1 & cur_q != CLS_SPIDER));
        pend_eff  = evt_cls > pend_q ? evt_cls : pend_q;
        if (!bus.sound_en) begin
            state_d = ST_IDLE;
            cur_d   = CLS_NONE;
            pend_d  = CLS_NONE;
        end else if (evt_cls > cur_q) begin
            // cur is NONE in IDLE, so this also covers starting from idle; pending survives a preempt
            next_cls = evt_cls;
        end else if (state_q != ST_IDLE) begin
            pend_d = pend_eff;
            if (to_idle) begin
                state_d  = ST_IDLE;
                cur_d    = CLS_NONE;
                pend_d   = CLS_NONE;
                next_cls = pend_eff;
            end else if (seg_end && state_q == ST_TONE1) begin
                state_d   = ST_GAP;
                seg_cnt_d = '0;
            end else if (seg_end && state_q == ST_GAP) begin
                state_d   = ST_TONE2;
                seg_cnt_d = '0;
                half_d    = CW'(SPIDER_HALF_B);
                restart   = 1'b1;
            end
        end
        if (next_cls != CLS_NONE) begin
            state_d   = ST_TONE1;
            cur_d     = next_cls;
            half_d    = half_of(next_cls);
            seg_cnt_d = '0;
            restart   = 1'b1;
        end
    end

    assign busy     = state_q != ST_IDLE;
    assign run      = state_q == ST_TONE1 || state_q == ST_TONE2;
    assign tone_out = square & run;
    assign buzz_d   = (bus.sound_en & busy) ? tone_out : bus.fire_buzz;

    tone_gen #(.W(CW)) u_tone (
        .clk25       (clk25),
        .reset       (reset),
        .restart     (restart),
        .run         (run),
        .half_period (half_q),
        .square      (square)
    );

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= CLS_NONE;
            pend_q      <= CLS_NONE;
            seg_cnt_q   <= '0;
            half_q      <= '0;
            prev_q      <= '0;
            hit_count_q <= '0;
            buzz_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            pend_q      <= pend_d;
            seg_cnt_q   <= seg_cnt_d;
            half_q      <= half_d;
            prev_q      <= prev_d;
            hit_count_q <= hit_count_d;
            buzz_q      <= buzz_d;
        end
    end

    assign bus.buzz       = buzz_q;
    assign bus.hit_active = busy;
    assign bus.hit_count  = hit_count_q;
endmodule

// File: tb/tb_hit_sound_controller.sv
// tb_hit_sound_controller: vector table, directed corner sequences and random stimulus vs. a timeline model
module tb_hit_sound_controller;
    localparam int TL = 20, GL = 4, FH = 2, MH = 3, HA = 4, HB = 5;

    logic clk25 = 1'b0;
    logic reset = 1'b1;

    hit_sound_controller_if #(.BULLET_COUNT(8)) bus ();

    hit_sound_controller #(
        .FLY_HALF      (FH),
        .MOSQ_HALF     (MH),
        .SPIDER_HALF_A (HA),
        .SPIDER_HALF_B (HB),
        .TONE_LEN      (TL),
        .GAP_LEN       (GL)
    ) dut (
        .clk25 (clk25),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk25 = ~clk25;

    int errors = 0;
    int checks = 0;

    // Model: the playing class and the cycle its tone began; everything else is elapsed-time arithmetic.
    int       m_t, m_cur, m_pend, m_t0, m_cnt;
    bit [2:0] m_prev;
    logic     exp_buzz, exp_act;
    int       act_cycles;

    typedef struct {
        logic       fire;
        logic [7:0] f, m, s;
        logic       eb;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic int dur(input int c);
        return c == 3 ? 2 * TL + GL : TL;
    endfunction

    function automatic logic tone_at(input int c, input int k);
        if (c == 3) begin
            if (k < TL) return ((k / HA) % 2) == 1;
            if (k < TL + GL) return 1'b0;
            return (((k - TL - GL) / HB) % 2) == 1;
        end
        return ((k / (c == 1 ? FH : MH)) % 2) == 1;
    endfunction

    task automatic model_reset();
        m_t = 0; m_cur = 0; m_pend = 0; m_t0 = 0; m_cnt = 0; m_prev = '0;
        exp_buzz = 1'b0; exp_act = 1'b0;
    endtask

    task automatic model_step();
        bit [2:0] a;
        int e = 0, n = 0, k;
        bit act;
        a = {|bus.bullet_hit_spider, |bus.bullet_hit_mosquito, |bus.bullet_hit_fly};
        for (int i = 0; i < 3; i++) if (a[i] && !m_prev[i]) begin n++; e = i + 1; end
        m_prev = a;
        act = m_cur != 0;
        k = m_t - m_t0;
        exp_buzz = (bus.sound_en && act) ? tone_at(m_cur, k) : bus.fire_buzz;
        m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
        if (!bus.sound_en) begin
            m_cur = 0; m_pend = 0;
        end else if (e > m_cur) begin
            m_cur = e; m_t0 = m_t + 1;
        end else begin
            if (e > m_pend) m_pend = e;
            if (act && k == dur(m_cur) - 1) begin
                m_cur = m_pend; m_t0 = m_t + 1; m_pend = 0;
            end
        end
        exp_act = m_cur != 0;
        m_t++;
    endtask

    task automatic tick();
        @(posedge clk25);
        model_step();
        @(negedge clk25);
        check("buzz", 16'(bus.buzz), 16'(exp_buzz));
        check("hit_active", 16'(bus.hit_active), 16'(exp_act));
        check("hit_count", 16'(bus.hit_count), 16'(m_cnt));
        if (bus.hit_active === 1'b1) act_cycles++;
    endtask

    task automatic drive(input logic [7:0] f, input logic [7:0] m, input logic [7:0] s,
                         input logic se, input logic fire);
        bus.bullet_hit_fly      = f;
        bus.bullet_hit_mosquito = m;
        bus.bullet_hit_spider   = s;
        bus.sound_en            = se;
        bus.fire_buzz           = fire;
    endtask

    task automatic do_reset();
        drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        @(negedge clk25);
        reset = 1'b1;
        model_reset();
        @(negedge clk25);
        reset = 1'b0;
        act_cycles = 0;
    endtask

    initial begin
        logic [7:0] rf, rm, rs;
        drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        model_reset();
        repeat (2) @(negedge clk25);
        check("reset_buzz", 16'(bus.buzz), 16'd0);
        check("reset_active", 16'(bus.hit_active), 16'd0);
        check("reset_count", 16'(bus.hit_count), 16'd0);
        reset = 1'b0;

        // sound_en=0: buzz is last cycle's fire_buzz, counter still tracks new hit edges
        tbl[0] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 8'd0};
        tbl[1] = '{1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 8'd1};
        tbl[2] = '{1'b1, 8'h01, 8'h00, 8'h00, 1'b1, 8'd1};
        tbl[3] = '{1'b1, 8'h00, 8'h80, 8'h02, 1'b1, 8'd3};
        tbl[4] = '{1'b0, 8'h04, 8'h80, 8'h02, 1'b0, 8'd4};
        tbl[5] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'd4};
        tbl[6] = '{1'b1, 8'h01, 8'h01, 8'h01, 1'b1, 8'd7};
        tbl[7] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'd7};
        foreach (tbl[i]) begin
            drive(tbl[i].f, tbl[i].m, tbl[i].s, 1'b0, tbl[i].fire);
            tick();
            check("tbl_buzz", 16'(bus.buzz), 16'(tbl[i].eb));
            check("tbl_active", 16'(bus.hit_active), 16'd0);
            check("tbl_count", 16'(bus.hit_count), 16'(tbl[i].ec));
        end

        // single fly pulse: 20 active cycles, buzz 0011... one cycle late, then fire_buzz
        do_reset();
        drive(8'h01, 8'h00, 8'h00, 1'b1, 1'b1);
        tick();
        drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        for (int j = 0; j < 30; j++) begin
            tick();
            if (j < 24) check("t1_buzz", 16'(bus.buzz), j < 20 ? 16'((j / 2) % 2) : 16'd1);
        end
        check("t1_active_len", 16'(act_cycles), 16'd20);
        check("t1_count", 16'(bus.hit_count), 16'd1);

        // held hit is one event
        do_reset();
        drive(8'h04, 8'h00, 8'h00, 1'b1, 1'b0);
        repeat (50) tick();
        drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        repeat (10) tick();
        check("t2_active_len", 16'(act_cycles), 16'd20);
        check("t2_count", 16'(bus.hit_count), 16'd1);

        // spider: tone, gap, tone
        do_reset();
        drive(8'h00, 8'h00, 8'h02, 1'b1, 1'b0);
        tick();
        drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        repeat (60) tick();
        check("t3_active_len", 16'(act_cycles), 16'd44);

        // mosquito, fly pending, spider preempts, fly plays afterwards
        do_reset();
        for (int c = 0; c < 90; c++) begin
            drive(c == 5 ? 8'h01 : 8'h00, c == 0 ? 8'h01 : 8'h00, c == 8 ? 8'h01 : 8'h00, 1'b1, 1'b0);
            tick();
        end
        check("t4_active_len", 16'(act_cycles), 16'd72);
        check("t4_count", 16'(bus.hit_count), 16'd3);

        // saturation
        do_reset();
        for (int p = 0; p < 300; p++) begin
            drive(8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
            tick();
            drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
            repeat (2) tick();
        end
        check("t5_saturate", 16'(bus.hit_count), 16'd255);

        // asynchronous reset in the spider gap
        do_reset();
        drive(8'h00, 8'h00, 8'h02, 1'b1, 1'b1);
        tick();
        drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        repeat (21) tick();
        check("t6_in_gap", 16'(bus.hit_active), 16'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_buzz", 16'(bus.buzz), 16'd0);
        check("t6_async_active", 16'(bus.hit_active), 16'd0);
        check("t6_async_count", 16'(bus.hit_count), 16'd0);
        model_reset();
        @(negedge clk25);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(8'h00, 8'h00, 8'h00, 1'b0, 1'((i * 7 / 3) % 2));
            tick();
            check("t6_fire_follow", 16'(bus.buzz), 16'((i * 7 / 3) % 2));
        end

        // random traffic
        do_reset();
        rf = '0; rm = '0; rs = '0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r  = $urandom_range(0, 15);
            rf = r == 0 ? 8'($urandom_range(1, 255)) : r < 4 ? rf : 8'h00;
            r  = $urandom_range(0, 19);
            rm = r == 0 ? 8'($urandom_range(1, 255)) : r < 4 ? rm : 8'h00;
            r  = $urandom_range(0, 29);
            rs = r == 0 ? 8'($urandom_range(1, 255)) : r < 4 ? rs : 8'h00;
            drive(rf, rm, rs, $urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
